lsu_bus_arbiter: RTL and testbench

- Shares one single-ported data/instruction RAM bus between two requesters: the LSU (load/store from the mem stage) and the IFU (instruction fetch).
- Converts each requester's single-cycle chip-enable request into a registered, multi-cycle bus transaction with ack handshake and timeout.
- Raises per-requester stall requests to ctrl until the transaction completes.
- Sits between the mem stage / IFU and the memory/peripheral bus.

---
 rtl/lsu_bus_arbiter_pkg.sv | 27 ++
 rtl/lsu_bus_arbiter_bus_watchdog.sv | 44 ++++
 rtl/lsu_bus_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_lsu_bus_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// lsu_bus_arbiter_pkg
// Shared types and constants for the LSU/IFU bus arbiter slice.
//   arb_state_e : arbiter FSM states (idle, busy per requester, done per requester)
//   grant_e     : identity of the requester that last won the bus
//   SEL_ALL     : byte-lane select used for every instruction fetch
//   RST_EN      : level of n_rst_i that holds the block in reset
// ---------------------------------------------------------------------------
package lsu_bus_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BUSY_L = 3'd1,
        ST_BUSY_I = 3'd2,
        ST_DONE_L = 3'd3,
        ST_DONE_I = 3'd4
    } arb_state_e;

    typedef enum logic {
        GRANT_LSU = 1'b0,
        GRANT_IFU = 1'b1
    } grant_e;

    localparam logic [3:0] SEL_ALL = 4'b1111;
    localparam logic       RST_EN  = 1'b0;

endpackage

// File: rtl/lsu_bus_arbiter_bus_watchdog.sv
// ---------------------------------------------------------------------------
// bus_watchdog
// Counts cycles spent waiting for a bus acknowledge and flags expiry.
//   i_clk    : clock, rising edge
//   i_rst_n  : asynchronous active-low reset
//   i_clear  : synchronously return the counter to zero
//   i_enable : count this cycle (transaction in flight)
//   o_expire : high during the last permitted wait cycle (TIMEOUT != 0)
// ---------------------------------------------------------------------------
module bus_watchdog
    import lsu_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int          CNT_W   = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    // The counter holds k during the k-th wait cycle (counting from 0), so
    // expiry fires on the cycle where it equals TIMEOUT-1, giving exactly
    // TIMEOUT wait cycles in total.
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;

    // Wait-cycle counter: cleared whenever no transaction is in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (i_rst_n == RST_EN) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // A zero TIMEOUT means wait forever.
    assign o_expire = (TIMEOUT != 0) && i_enable && (r_cnt == LIMIT);

endmodule

// File: rtl/lsu_bus_arbiter.sv
// ---------------------------------------------------------------------------
// lsu_bus_arbiter
// Shares one single-ported RAM/peripheral bus between the LSU and the IFU.
// Each single-cycle chip-enable becomes a registered bus transaction that
// waits for bus_ack_i (or a timeout), then pulses the requester's done.
//   clk_i, n_rst_i          : clock and asynchronous active-low reset
//   lsu_*_i / lsu_*_o       : load/store request, result, done, error, stall
//   ifu_*_i / ifu_*_o       : fetch request, result, done, error, stall
//   bus_*_o / bus_*_i       : shared bus master side (req, we, addr, sel,
//                             wdata out; rdata, ack in)
// ---------------------------------------------------------------------------
module lsu_bus_arbiter
    import lsu_bus_arbiter_pkg::*;
#(
    parameter int          AW      = 32,
    parameter int          DW      = 32,
    parameter int unsigned TIMEOUT = 255,
    parameter int          CNT_W   = 8
) (
    input  logic          clk_i,
    input  logic          n_rst_i,

    input  logic          lsu_ce_i,
    input  logic          lsu_we_i,
    input  logic [AW-1:0] lsu_addr_i,
    input  logic [3:0]    lsu_sel_i,
    input  logic [DW-1:0] lsu_wdata_i,
    output logic [DW-1:0] lsu_rdata_o,
    output logic          lsu_done_o,
    output logic          lsu_err_o,
    output logic          lsu_stall_o,

    input  logic          ifu_ce_i,
    input  logic [AW-1:0] ifu_addr_i,
    output logic [DW-1:0] ifu_rdata_o,
    output logic          ifu_done_o,
    output logic          ifu_err_o,
    output logic          ifu_stall_o,

    output logic          bus_req_o,
    output logic          bus_we_o,
    output logic [AW-1:0] bus_addr_o,
    output logic [3:0]    bus_sel_o,
    output logic [DW-1:0] bus_wdata_o,
    input  logic [DW-1:0] bus_rdata_i,
    input  logic          bus_ack_i
);

    arb_state_e    r_state;
    arb_state_e    w_next;
    grant_e        r_lastGrant;
    logic          w_grantLsu;
    logic          w_grantIfu;
    logic          w_busy;
    logic          w_expire;

    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [3:0]    r_sel;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_lsuRdata;
    logic [DW-1:0] r_ifuRdata;
    logic          r_lsuErr;
    logic          r_ifuErr;

    assign w_busy = (r_state == ST_BUSY_L) || (r_state == ST_BUSY_I);

    // Timeout counter runs only while a transaction waits for its ack.
    bus_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_watchdog (
        .i_clk    (clk_i),
        .i_rst_n  (n_rst_i),
        .i_clear  (~w_busy),
        .i_enable (w_busy),
        .o_expire (w_expire)
    );

    // FSM state register; reset abandons any transaction in flight.
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (n_rst_i == RST_EN) begin
            r_state     <= ST_IDLE;
            r_lastGrant <= GRANT_IFU;
        end else begin
            r_state <= w_next;
            if (w_grantLsu) begin
                r_lastGrant <= GRANT_LSU;
            end else if (w_grantIfu) begin
                r_lastGrant <= GRANT_IFU;
            end
        end
    end

    // Next-state and grant decode. On a tie the LSU wins only if the IFU
    // was served last, so the two requesters alternate and neither starves.
    // An ack on the expiry cycle takes the normal-completion path because
    // both conditions lead to the same DONE state; only the result differs.
    always_comb begin
        w_next     = r_state;
        w_grantLsu = 1'b0;
        w_grantIfu = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (lsu_ce_i && (!ifu_ce_i || (r_lastGrant == GRANT_IFU))) begin
                    w_grantLsu = 1'b1;
                    w_next     = ST_BUSY_L;
                end else if (ifu_ce_i) begin
                    w_grantIfu = 1'b1;
                    w_next     = ST_BUSY_I;
                end
            end
            ST_BUSY_L: begin
                if (bus_ack_i || w_expire) begin
                    w_next = ST_DONE_L;
                end
            end
            ST_BUSY_I: begin
                if (bus_ack_i || w_expire) begin
                    w_next = ST_DONE_I;
                end
            end
            ST_DONE_L: w_next = ST_IDLE;
            ST_DONE_I: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Bus request fields are captured on the grant and held for the whole
    // transaction. Fetches are always full-word reads.
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (n_rst_i == RST_EN) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_sel   <= '0;
            r_wdata <= '0;
        end else if (w_grantLsu) begin
            r_we    <= lsu_we_i;
            r_addr  <= lsu_addr_i;
            r_sel   <= lsu_sel_i;
            r_wdata <= lsu_wdata_i;
        end else if (w_grantIfu) begin
            r_we    <= 1'b0;
            r_addr  <= ifu_addr_i;
            r_sel   <= SEL_ALL;
            r_wdata <= '0;
        end
    end

    // Result capture on completion. Stores keep the previous load data;
    // a timeout zeroes the data and flags an error. Results persist until
    // the same requester completes again.
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (n_rst_i == RST_EN) begin
            r_lsuRdata <= '0;
            r_lsuErr   <= 1'b0;
            r_ifuRdata <= '0;
            r_ifuErr   <= 1'b0;
        end else begin
            if (r_state == ST_BUSY_L) begin
                if (bus_ack_i) begin
                    if (!r_we) begin
                        r_lsuRdata <= bus_rdata_i;
                    end
                    r_lsuErr <= 1'b0;
                end else if (w_expire) begin
                    r_lsuRdata <= '0;
                    r_lsuErr   <= 1'b1;
                end
            end
            if (r_state == ST_BUSY_I) begin
                if (bus_ack_i) begin
                    r_ifuRdata <= bus_rdata_i;
                    r_ifuErr   <= 1'b0;
                end else if (w_expire) begin
                    r_ifuRdata <= '0;
                    r_ifuErr   <= 1'b1;
                end
            end
        end
    end

    assign bus_req_o   = w_busy;
    assign bus_we_o    = r_we;
    assign bus_addr_o  = r_addr;
    assign bus_sel_o   = r_sel;
    assign bus_wdata_o = r_wdata;

    assign lsu_done_o  = (r_state == ST_DONE_L);
    assign ifu_done_o  = (r_state == ST_DONE_I);
    assign lsu_rdata_o = r_lsuRdata;
    assign lsu_err_o   = r_lsuErr;
    assign ifu_rdata_o = r_ifuRdata;
    assign ifu_err_o   = r_ifuErr;

    // Stall drops in the done cycle so the pipeline advances with the result.
    assign lsu_stall_o = lsu_ce_i & ~lsu_done_o;
    assign ifu_stall_o = ifu_ce_i & ~ifu_done_o;

endmodule

// File: tb/tb_lsu_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lsu_bus_arbiter
// Directed bench for lsu_bus_arbiter built with TIMEOUT=4. The bench plays
// the bus slave itself, driving ack/rdata cycle by cycle, and compares every
// output against hand-computed values.
// ---------------------------------------------------------------------------
module tb_lsu_bus_arbiter;

    logic        clk;
    logic        n_rst;
    logic        lsuCe;
    logic        lsuWe;
    logic [31:0] lsuAddr;
    logic [3:0]  lsuSel;
    logic [31:0] lsuWdata;
    logic [31:0] lsuRdata;
    logic        lsuDone;
    logic        lsuErr;
    logic        lsuStall;
    logic        ifuCe;
    logic [31:0] ifuAddr;
    logic [31:0] ifuRdata;
    logic        ifuDone;
    logic        ifuErr;
    logic        ifuStall;
    logic        busReq;
    logic        busWe;
    logic [31:0] busAddr;
    logic [3:0]  busSel;
    logic [31:0] busWdata;
    logic [31:0] busRdata;
    logic        busAck;

    int assertCount = 0;
    int failCount   = 0;

    lsu_bus_arbiter #(
        .AW      (32),
        .DW      (32),
        .TIMEOUT (4),
        .CNT_W   (3)
    ) dut (
        .clk_i       (clk),
        .n_rst_i     (n_rst),
        .lsu_ce_i    (lsuCe),
        .lsu_we_i    (lsuWe),
        .lsu_addr_i  (lsuAddr),
        .lsu_sel_i   (lsuSel),
        .lsu_wdata_i (lsuWdata),
        .lsu_rdata_o (lsuRdata),
        .lsu_done_o  (lsuDone),
        .lsu_err_o   (lsuErr),
        .lsu_stall_o (lsuStall),
        .ifu_ce_i    (ifuCe),
        .ifu_addr_i  (ifuAddr),
        .ifu_rdata_o (ifuRdata),
        .ifu_done_o  (ifuDone),
        .ifu_err_o   (ifuErr),
        .ifu_stall_o (ifuStall),
        .bus_req_o   (busReq),
        .bus_we_o    (busWe),
        .bus_addr_o  (busAddr),
        .bus_sel_o   (busSel),
        .bus_wdata_o (busWdata),
        .bus_rdata_i (busRdata),
        .bus_ack_i   (busAck)
    );

    // 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Moves to 2 time units after the next rising edge.
    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    // Drives every DUT input for the current cycle, then lets logic settle.
    task automatic applyStimulus(input logic lce, input logic lwe, input logic [31:0] laddr,
                                 input logic [3:0] lsel, input logic [31:0] lwdata,
                                 input logic ice, input logic [31:0] iaddr,
                                 input logic ack, input logic [31:0] rdata);
        lsuCe    = lce;
        lsuWe    = lwe;
        lsuAddr  = laddr;
        lsuSel   = lsel;
        lsuWdata = lwdata;
        ifuCe    = ice;
        ifuAddr  = iaddr;
        busAck   = ack;
        busRdata = rdata;
        #1;
    endtask

    initial begin
        n_rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        $display("[TB] reset state");
        checkOutput("rst_busReq", {31'd0, busReq}, 0);
        checkOutput("rst_lsuDone", {31'd0, lsuDone}, 0);
        checkOutput("rst_ifuDone", {31'd0, ifuDone}, 0);
        checkOutput("rst_lsuErr", {31'd0, lsuErr}, 0);
        checkOutput("rst_lsuRdata", lsuRdata, 0);
        nextCycle();
        nextCycle();
        n_rst = 1'b1;

        // ---- LSU load, ack after two busy cycles ----
        $display("[TB] LSU load");
        applyStimulus(1, 0, 32'h100, 4'b0101, 0, 0, 0, 0, 0);
        checkOutput("t1_c0_req", {31'd0, busReq}, 0);
        checkOutput("t1_c0_stall", {31'd0, lsuStall}, 1);
        nextCycle();
        applyStimulus(1, 0, 32'h100, 4'b0101, 0, 0, 0, 0, 0);
        checkOutput("t1_c1_req", {31'd0, busReq}, 1);
        checkOutput("t1_c1_addr", busAddr, 32'h100);
        checkOutput("t1_c1_we", {31'd0, busWe}, 0);
        checkOutput("t1_c1_sel", {28'd0, busSel}, 4'b0101);
        checkOutput("t1_c1_stall", {31'd0, lsuStall}, 1);
        nextCycle();
        applyStimulus(1, 0, 32'h100, 4'b0101, 0, 0, 0, 1, 32'hDEADBEEF);
        checkOutput("t1_c2_req", {31'd0, busReq}, 1);
        checkOutput("t1_c2_done", {31'd0, lsuDone}, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t1_c3_done", {31'd0, lsuDone}, 1);
        checkOutput("t1_c3_rdata", lsuRdata, 32'hDEADBEEF);
        checkOutput("t1_c3_err", {31'd0, lsuErr}, 0);
        checkOutput("t1_c3_req", {31'd0, busReq}, 0);
        nextCycle();
        checkOutput("t1_c4_done", {31'd0, lsuDone}, 0);

        // Fresh reset so the last grant is the IFU again.
        n_rst = 1'b0;
        nextCycle();
        n_rst = 1'b1;

        // ---- simultaneous LSU store and IFU fetch ----
        $display("[TB] simultaneous store and fetch");
        applyStimulus(1, 1, 32'h200, 4'b0011, 32'h12345678, 1, 32'h0, 0, 0);
        nextCycle();
        applyStimulus(1, 1, 32'h200, 4'b0011, 32'h12345678, 1, 32'h0, 1, 32'hAAAA5555);
        checkOutput("t2_L_req", {31'd0, busReq}, 1);
        checkOutput("t2_L_we", {31'd0, busWe}, 1);
        checkOutput("t2_L_addr", busAddr, 32'h200);
        checkOutput("t2_L_wdata", busWdata, 32'h12345678);
        checkOutput("t2_L_sel", {28'd0, busSel}, 4'b0011);
        checkOutput("t2_L_istall", {31'd0, ifuStall}, 1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h0, 0, 0);
        checkOutput("t2_Ldone", {31'd0, lsuDone}, 1);
        checkOutput("t2_store_rdata", lsuRdata, 32'h0);
        checkOutput("t2_Ldone_istall", {31'd0, ifuStall}, 1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h0, 0, 0);
        checkOutput("t2_idle_req", {31'd0, busReq}, 0);
        checkOutput("t2_idle_istall", {31'd0, ifuStall}, 1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h0, 1, 32'h00000013);
        checkOutput("t2_I_req", {31'd0, busReq}, 1);
        checkOutput("t2_I_we", {31'd0, busWe}, 0);
        checkOutput("t2_I_sel", {28'd0, busSel}, 4'b1111);
        checkOutput("t2_I_addr", busAddr, 32'h0);
        checkOutput("t2_I_istall", {31'd0, ifuStall}, 1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t2_Idone", {31'd0, ifuDone}, 1);
        checkOutput("t2_Irdata", ifuRdata, 32'h00000013);
        nextCycle();

        // ---- both held: grants alternate L, I, L, I, L, I ----
        $display("[TB] alternating grants");
        for (int i = 0; i < 6; i++) begin
            logic expL;
            expL = (i % 2 == 0);
            applyStimulus(1, 0, 32'h300, 4'b1111, 0, 1, 32'h400, 0, 0);
            nextCycle();
            applyStimulus(1, 0, 32'h300, 4'b1111, 0, 1, 32'h400, 1, 32'h1000 + i);
            checkOutput($sformatf("t3_%0d_addr", i), busAddr, expL ? 32'h300 : 32'h400);
            nextCycle();
            applyStimulus(1, 0, 32'h300, 4'b1111, 0, 1, 32'h400, 0, 0);
            checkOutput($sformatf("t3_%0d_ldone", i), {31'd0, lsuDone}, {31'd0, expL});
            checkOutput($sformatf("t3_%0d_idone", i), {31'd0, ifuDone}, {31'd0, ~expL});
            checkOutput($sformatf("t3_%0d_rdata", i), expL ? lsuRdata : ifuRdata, 32'h1000 + i);
            nextCycle();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // ---- timeout with no ack, then ack on the last permitted cycle ----
        $display("[TB] timeout");
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h40, 0, 0);
        for (int k = 0; k < 4; k++) begin
            nextCycle();
            applyStimulus(0, 0, 0, 0, 0, 1, 32'h40, 0, 0);
            checkOutput($sformatf("t4a_req%0d", k), {31'd0, busReq}, 1);
        end
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t4a_req_end", {31'd0, busReq}, 0);
        checkOutput("t4a_done", {31'd0, ifuDone}, 1);
        checkOutput("t4a_err", {31'd0, ifuErr}, 1);
        checkOutput("t4a_rdata", ifuRdata, 32'h0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h44, 0, 0);
        for (int k = 0; k < 4; k++) begin
            nextCycle();
            applyStimulus(0, 0, 0, 0, 0, 1, 32'h44, (k == 3), 32'hCAFEF00D);
            checkOutput($sformatf("t4b_req%0d", k), {31'd0, busReq}, 1);
        end
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t4b_done", {31'd0, ifuDone}, 1);
        checkOutput("t4b_err", {31'd0, ifuErr}, 0);
        checkOutput("t4b_rdata", ifuRdata, 32'hCAFEF00D);
        nextCycle();

        // ---- IFU flush mid-transaction, pending LSU served afterwards ----
        $display("[TB] IFU flush");
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h80, 0, 0);
        nextCycle();
        applyStimulus(1, 0, 32'h500, 4'b1100, 0, 0, 0, 0, 0);
        checkOutput("t5_drop_istall", {31'd0, ifuStall}, 0);
        checkOutput("t5_drop_req", {31'd0, busReq}, 1);
        nextCycle();
        applyStimulus(1, 0, 32'h500, 4'b1100, 0, 0, 0, 1, 32'h77);
        checkOutput("t5_busy_lstall", {31'd0, lsuStall}, 1);
        nextCycle();
        applyStimulus(1, 0, 32'h500, 4'b1100, 0, 0, 0, 0, 0);
        checkOutput("t5_idone", {31'd0, ifuDone}, 1);
        checkOutput("t5_irdata", ifuRdata, 32'h77);
        nextCycle();
        applyStimulus(1, 0, 32'h500, 4'b1100, 0, 0, 0, 0, 0);
        checkOutput("t5_idle_req", {31'd0, busReq}, 0);
        nextCycle();
        applyStimulus(1, 0, 32'h500, 4'b1100, 0, 0, 0, 1, 32'h55);
        checkOutput("t5_L_addr", busAddr, 32'h500);
        checkOutput("t5_L_sel", {28'd0, busSel}, 4'b1100);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t5_ldone", {31'd0, lsuDone}, 1);
        checkOutput("t5_lrdata", lsuRdata, 32'h55);
        nextCycle();

        // ---- asynchronous reset during BUSY_L ----
        $display("[TB] reset mid-transaction");
        applyStimulus(1, 0, 32'h600, 4'b1111, 0, 0, 0, 0, 0);
        nextCycle();
        applyStimulus(1, 0, 32'h600, 4'b1111, 0, 0, 0, 0, 0);
        checkOutput("t6_busy_req", {31'd0, busReq}, 1);
        #1;
        n_rst = 1'b0;
        #1;
        checkOutput("t6_rst_req", {31'd0, busReq}, 0);
        checkOutput("t6_rst_ldone", {31'd0, lsuDone}, 0);
        checkOutput("t6_rst_lerr", {31'd0, lsuErr}, 0);
        checkOutput("t6_rst_lrdata", lsuRdata, 32'h0);
        checkOutput("t6_rst_irdata", ifuRdata, 32'h0);
        nextCycle();
        n_rst = 1'b1;
        applyStimulus(1, 0, 32'h600, 4'b1111, 0, 0, 0, 0, 0);
        checkOutput("t6_idle_req", {31'd0, busReq}, 0);
        nextCycle();
        applyStimulus(1, 0, 32'h600, 4'b1111, 0, 0, 0, 1, 32'h66);
        checkOutput("t6_min_req", {31'd0, busReq}, 1);
        checkOutput("t6_min_addr", busAddr, 32'h600);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t6_ldone", {31'd0, lsuDone}, 1);
        checkOutput("t6_lrdata", lsuRdata, 32'h66);
        nextCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
